// File: rtl/reg_dump_ctrl_pkg.sv
// rtl/reg_dump_ctrl_pkg.sv - shared constants and state encoding for the register dump engine
package reg_dump_ctrl_pkg;

   localparam int REG_COUNT  = 32;
   localparam int REG_ADDR_W = 5;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      SEND  = 2'd2,
      DONE  = 2'd3
   } dump_state_t;

endpackage

// File: rtl/reg_dump_ctrl.sv
// rtl/reg_dump_ctrl.sv - stalls the core and streams x0..x(NUM_REGS-1) out over valid/ready
module reg_dump_ctrl
   import reg_dump_ctrl_pkg::*;
#(
   parameter int NUM_REGS = REG_COUNT,
   parameter int ADDR_W   = REG_ADDR_W,
   parameter int DATA_W   = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              hold_core,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] rf_addr,
   input  logic [DATA_W-1:0] rf_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [ADDR_W-1:0] out_index
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

   dump_state_t       state;
   dump_state_t       state_next;
   logic [ADDR_W-1:0] idx;
   logic [ADDR_W-1:0] idx_next;
   logic              capture;

   // State, walk index and the captured output word; the word only changes on a FETCH edge
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         idx       <= '0;
         out_data  <= '0;
         out_index <= '0;
      end else begin
         state <= state_next;
         idx   <= idx_next;
         if (capture) begin
            out_data  <= rf_data;
            out_index <= idx;
         end
      end
   end

   // Next-state and index sequencing; out_ready only steers the next state, never an output
   always_comb begin
      state_next = state;
      idx_next   = idx;
      capture    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               idx_next   = '0;
               state_next = FETCH;
            end
         end
         FETCH: begin
            capture    = 1'b1;
            state_next = SEND;
         end
         SEND: begin
            if (out_ready) begin
               if (idx == LAST_IDX) begin
                  state_next = DONE;
               end else begin
                  idx_next   = idx + ADDR_W'(1);
                  state_next = FETCH;
               end
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Core stall spans FETCH through DONE so the register file is frozen for the whole walk
   assign hold_core = (state != IDLE);
   assign busy      = hold_core;
   assign done      = (state == DONE);
   assign out_valid = (state == SEND);
   assign rf_addr   = idx;

endmodule

// File: tb/tb_reg_dump_ctrl.sv
// tb/tb_reg_dump_ctrl.sv - vector table plus model-checked dumps for reg_dump_ctrl
module tb_reg_dump_ctrl;

   localparam int NR = 32;
   localparam int AW = 5;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          hold_core;
   logic          busy;
   logic          done;
   logic [AW-1:0] rf_addr;
   logic [DW-1:0] rf_data;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic [AW-1:0] out_index;

   logic [DW-1:0] mem [NR];

   int vectors     = 0;
   int miscompares = 0;
   int cyc         = 0;

   typedef struct packed {
      logic          rst;
      logic          start;
      logic          ready;
      logic          hold;
      logic          valid;
      logic          dn;
      logic [AW-1:0] addr;
      logic [AW-1:0] oidx;
      logic [DW-1:0] odata;
   } vec_t;

   vec_t tbl [$];

   reg_dump_ctrl #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .hold_core (hold_core),
      .busy      (busy),
      .done      (done),
      .rf_addr   (rf_addr),
      .rf_data   (rf_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_index (out_index)
   );

   // Register file read port modelled as a plain array lookup
   assign rf_data = mem[rf_addr];

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic vec_t mk(input logic r, input logic s, input logic rd,
                               input logic h, input logic v, input logic d,
                               input int a, input int oi, input logic [DW-1:0] od);
      vec_t x;
      x.rst   = r;
      x.start = s;
      x.ready = rd;
      x.hold  = h;
      x.valid = v;
      x.dn    = d;
      x.addr  = AW'(a);
      x.oidx  = AW'(oi);
      x.odata = od;
      return x;
   endfunction

   task automatic fill_pattern();
      for (int i = 0; i < NR; i++) mem[i] = (i == 0) ? 32'h0 : 32'hA5A5_0000 + 32'(i);
   endtask

   task automatic fill_random();
      for (int i = 0; i < NR; i++) mem[i] = $urandom;
   endtask

   task automatic check_idle(input string tag);
      chk({tag, ".hold"},  32'(hold_core), 32'h0);
      chk({tag, ".busy"},  32'(busy),      32'h0);
      chk({tag, ".done"},  32'(done),      32'h0);
      chk({tag, ".valid"}, 32'(out_valid), 32'h0);
      chk({tag, ".addr"},  32'(rf_addr),   32'h0);
      chk({tag, ".oidx"},  32'(out_index), 32'h0);
      chk({tag, ".odata"}, out_data,       32'h0);
   endtask

   // mode 0: ready always high; mode 1: five stall cycles on index 7; mode 2: random ready
   task automatic run_dump(input int mode, input bit poke, input string tag);
      int n;
      int k;
      int stalls;
      int stall7;
      int done_rel;
      int exp_lat;
      start     = 1'b1;
      out_ready = 1'b1;
      step();
      start    = 1'b0;
      n        = cyc;
      k        = 0;
      stalls   = 0;
      stall7   = 0;
      done_rel = -1;
      for (int t = 0; t < 1000; t++) begin
         if (done) begin
            done_rel = cyc - n;
            break;
         end
         chk({tag, ".hold"}, 32'(hold_core), 32'h1);
         start = 1'b0;
         if (out_valid) begin
            if (k < NR) begin
               chk({tag, ".index"}, 32'(out_index), 32'(k));
               chk({tag, ".data"},  out_data,       mem[k]);
            end else begin
               chk({tag, ".extra_word"}, 32'(k), 32'(NR - 1));
            end
            case (mode)
               1: begin
                  if (out_index == AW'(7) && stall7 < 5) begin
                     out_ready = 1'b0;
                     stall7++;
                  end else begin
                     out_ready = 1'b1;
                  end
               end
               2:       out_ready = ($urandom_range(0, 3) != 0);
               default: out_ready = 1'b1;
            endcase
            if (out_ready) k++;
            else stalls++;
            if (poke && out_index == AW'(12)) start = 1'b1;
         end else begin
            out_ready = (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
         end
         step();
      end
      exp_lat = (mode == 1) ? 69 : 64 + stalls;
      chk({tag, ".done_latency"}, 32'(done_rel), 32'(exp_lat));
      chk({tag, ".words"},        32'(k),        32'(NR));
      start = 1'b0;
      step();
      chk({tag, ".done_once"}, 32'(done), 32'h0);
      chk({tag, ".busy_fall"}, 32'(busy), 32'h0);
      if (poke) begin
         for (int t = 0; t < 8; t++) begin
            step();
            chk({tag, ".no_restart"}, 32'(busy), 32'h0);
         end
      end
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      out_ready = 1'b0;
      fill_pattern();

      // Reset, idle, then a short dump with backpressure cut short by reset
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h0));
      tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 32'h0));
      for (int i = 0; i < 10; i++) tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0));
      tbl.push_back(mk(0, 1, 1, 1, 0, 0, 0, 0, 32'h0));
      tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 32'h0));
      tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 32'h0));
      tbl.push_back(mk(0, 0, 1, 1, 0, 0, 1, 0, 32'h0));
      tbl.push_back(mk(0, 0, 1, 1, 1, 0, 1, 1, 32'hA5A5_0001));
      tbl.push_back(mk(0, 0, 0, 1, 1, 0, 1, 1, 32'hA5A5_0001));
      tbl.push_back(mk(0, 0, 1, 1, 0, 0, 2, 1, 32'hA5A5_0001));
      tbl.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 32'h0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 32'h0));

      foreach (tbl[i]) begin
         rst       = tbl[i].rst;
         start     = tbl[i].start;
         out_ready = tbl[i].ready;
         step();
         chk($sformatf("tbl[%0d].hold", i),  32'(hold_core), 32'(tbl[i].hold));
         chk($sformatf("tbl[%0d].busy", i),  32'(busy),      32'(tbl[i].hold));
         chk($sformatf("tbl[%0d].done", i),  32'(done),      32'(tbl[i].dn));
         chk($sformatf("tbl[%0d].valid", i), 32'(out_valid), 32'(tbl[i].valid));
         chk($sformatf("tbl[%0d].addr", i),  32'(rf_addr),   32'(tbl[i].addr));
         chk($sformatf("tbl[%0d].oidx", i),  32'(out_index), 32'(tbl[i].oidx));
         chk($sformatf("tbl[%0d].odata", i), out_data,       tbl[i].odata);
      end
      rst   = 1'b0;
      start = 1'b0;

      run_dump(0, 1'b0, "full");
      run_dump(1, 1'b0, "backpressure");
      run_dump(0, 1'b1, "start_busy");

      // Reset while SEND presents index 20: everything clears and no done follows
      begin
         bit seen_done;
         bit seen_busy;
         fill_random();
         start     = 1'b1;
         out_ready = 1'b1;
         step();
         start = 1'b0;
         for (int t = 0; t < 200; t++) begin
            if (out_valid && out_index == AW'(20)) break;
            step();
         end
         chk("midrst.reach_valid", 32'(out_valid), 32'h1);
         chk("midrst.reach_index", 32'(out_index), 32'd20);
         rst = 1'b1;
         step();
         rst = 1'b0;
         check_idle("midrst");
         seen_done = 1'b0;
         seen_busy = 1'b0;
         for (int t = 0; t < 80; t++) begin
            step();
            if (done) seen_done = 1'b1;
            if (busy) seen_busy = 1'b1;
         end
         chk("midrst.no_done", 32'(seen_done), 32'h0);
         chk("midrst.no_busy", 32'(seen_busy), 32'h0);
      end

      // start held high: two dumps separated by exactly one IDLE cycle
      begin
         int words;
         fill_pattern();
         start     = 1'b1;
         out_ready = 1'b1;
         step();
         words = 0;
         for (int j = 0; j <= 130; j++) begin
            chk($sformatf("b2b.hold[%0d]", j), 32'(hold_core), (j == 65) ? 32'h0 : 32'h1);
            chk($sformatf("b2b.done[%0d]", j), 32'(done), (j == 64 || j == 130) ? 32'h1 : 32'h0);
            if (out_valid && out_ready) words++;
            step();
         end
         start = 1'b0;
         chk("b2b.words", 32'(words), 32'd64);
         chk("b2b.idle_after", 32'(busy), 32'h0);
         step();
         chk("b2b.stays_idle", 32'(busy), 32'h0);
      end

      for (int r = 0; r < 4; r++) begin
         fill_random();
         run_dump(2, 1'b0, $sformatf("rand%0d", r));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/reg_dump_ctrl.md
# reg_dump_ctrl

Debug read-out engine for the RV32I register file. On a start request it stalls the core, walks x0..x31 through a spare combinational read port of the register file, and streams each value out over a valid/ready handshake, typically to a UART transmitter or testbench monitor. It sits beside the single-cycle core and is the consumer of the register file's read interface.

## Interface

Parameters:
- NUM_REGS, 32: number of registers walked, always starting from index 0.
- ADDR_W, 5: register index width; must satisfy 2^ADDR_W >= NUM_REGS.
- DATA_W, 32: register width.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  dump request; sampled only in IDLE.
- hold_core  out  1  core stall; high whenever the FSM is not in IDLE.
- busy  out  1  dump in progress; equal to hold_core.
- done  out  1  one-cycle pulse after the last register is accepted.
- rf_addr  out  ADDR_W  read index driven to the register file read port.
- rf_data  in  DATA_W  combinational read data returned for rf_addr.
- out_valid  out  1  out_data and out_index are valid.
- out_ready  in  1  sink accepts the current word.
- out_data  out  DATA_W  captured register value.
- out_index  out  ADDR_W  index of out_data.

## Operation

- States: IDLE, FETCH, SEND, DONE. The state, index counter, out_data and out_index are registers.
- **IDLE**
  - start=1: idx <= 0, go to FETCH.
  - start=0: stay in IDLE.
- **FETCH**
  - rf_addr = idx.
  - At the edge: out_data <= rf_data, out_index <= idx, go to SEND.
- **SEND**
  - out_valid=1.
  - out_ready=1 and idx==NUM_REGS-1: go to DONE.
  - out_ready=1 otherwise: idx <= idx+1, go to FETCH.
  - out_ready=0: stay in SEND. out_data and out_index hold.
- **DONE**
  - done=1 for this cycle only, then go to IDLE.
- hold_core is asserted from FETCH through DONE, so the core does not write registers during the dump. The snapshot is therefore atomic.
- start is ignored outside IDLE, including in DONE.
- rf_addr equals idx in every state. It is 0 in IDLE after reset.
- x0 is read like any other register and is expected to return 0. The block does not special-case it.

## Timing

- Reset values: state=IDLE, idx=0, rf_addr=0, out_data=0, out_index=0, out_valid=0, busy=0, hold_core=0, done=0.
- start is high at edge N. FETCH occupies cycle N+1, and out_valid is first high in cycle N+2.
- With out_ready tied high, each register takes 2 cycles (FETCH, SEND):
  - the last word is accepted at the end of cycle N+64;
  - done is high in cycle N+65;
  - busy falls in cycle N+66.
- Each cycle with out_ready low while in SEND adds one cycle of latency. There is no data loss.
- No combinational path from out_ready to out_valid or out_data.
- rst=1 in any state returns every register to its reset value at the next edge. A dump interrupted this way is not resumed and does not produce done.
- start held high continuously: a new dump begins in the IDLE cycle following DONE, so the minimum gap is one IDLE cycle.

## Structure

- Shared package (core-wide constants):
  - state encodings IDLE=2'd0, FETCH=2'd1, SEND=2'd2, DONE=2'd3;
  - REG_COUNT=32;
  - REG_ADDR_W=5.
- No sub-module. The counter and FSM are small enough to live in one module.
- Top-level integration:
  - rf_addr is muxed onto the register file's src1 read index while hold_core is high;
  - hold_core gates the PC update and reg_write_control.

## Test plan

- **Reset and idle.** Assert rst for 2 cycles, then hold start=0 for 10 cycles. All outputs stay at their reset values and rf_addr=0.
- **Full dump, no backpressure.** Preload x_i = 0xA5A50000+i and keep out_ready=1, then pulse start.
  - 32 words appear with out_index 0..31.
  - out_data is 0, 0xA5A50001, …, 0xA5A5001F.
  - done pulses exactly in cycle N+65.
- **Backpressure.**
  - Hold out_ready=0 for 5 cycles on index 7. out_valid, out_data=0xA5A50007 and out_index=7 stay stable.
  - Total latency grows by exactly 5.
- **start while busy.** Pulse start again at index 12. The dump continues uninterrupted, done pulses once, and no second dump starts.
- **Reset mid-dump.** Assert rst while in SEND at index 20. Next cycle everything is at reset values and busy=0, and no done pulse occurs.
- **Back-to-back.** Hold start=1 throughout. Two complete dumps run, separated by exactly one IDLE cycle, with hold_core low only in that cycle.
